// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with midpoint
// sampling, feeding a first-word-fall-through receive FIFO with sticky error flags.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] dout,
    output logic       rd_rdy,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);
    localparam int CNTW = $clog2(CLKS_PER_BIT);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CLKS_PER_BIT - 1);
    localparam logic [CNTW-1:0] CNT_MID  = CNTW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HI
    } state_t;

    state_t          state, state_nxt;
    logic            rx_meta, rx_s;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic [2:0]      bit_idx, bit_idx_nxt;
    logic [7:0]      shreg, shreg_nxt;
    logic            cnt_done, par_ok, push_req, frame_set;

    assign cnt_done = (cnt == CNT_LAST);

`ifdef UART_RX_PARITY_EN
    logic par_bit, par_nxt;
    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_ok = ~(^{shreg, par_bit});
    always_ff @(posedge clk) begin
        if (rst) par_bit <= 1'b0;
        else     par_bit <= par_nxt;
    end
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        push_req    = 1'b0;
        frame_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt     = par_bit;
`endif
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) state_nxt = S_START;
            end
            S_START: begin
                if (cnt == CNT_MID) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_done) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {rx_s, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx == 3'd7) state_nxt = S_PARITY;
`else
                    if (bit_idx == 3'd7) state_nxt = S_STOP;
`endif
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_done) begin
                    cnt_nxt   = '0;
                    par_nxt   = rx_s;
                    state_nxt = S_STOP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_done) begin
                    cnt_nxt = '0;
                    if (rx_s && par_ok) begin
                        push_req  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        // A low stop bit means the line may be in break; wait for it to rise.
                        frame_set = 1'b1;
                        state_nxt = rx_s ? S_IDLE : S_WAIT_HI;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_WAIT_HI: begin
                if (rx_s) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, pop, push;

    assign full   = (count == CNT_FULL);
    assign rd_rdy = (count != '0);
    assign pop    = rd_en & rd_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push   = push_req & (~full | pop);
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (frame_set)    frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
            if (push_req && !push) overrun <= 1'b1;
            else if (err_clr)      overrun <= 1'b0;
        end
    end

    assign rx_busy = (state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: frame table plus hand-written corner sequences,
// received bytes checked against a scoreboard queue.
module tb_uart_rx_fifo;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, rx, rd_en, err_clr;
    logic [7:0] dout;
    logic       rd_rdy, frame_err, overrun, rx_busy;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .err_clr(err_clr),
        .dout(dout), .rd_rdy(rd_rdy), .frame_err(frame_err), .overrun(overrun),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       exp_ferr;
    } vec_t;

    vec_t       vt[8];
    logic [7:0] sbq[$];
    int         nvec = 0;
    int         nerr = 0;
    int         rise_at;
    logic       exp_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame; records the frame-relative cycle at which rd_rdy first rises.
    task automatic send(input logic [7:0] d, input logic stop, input logic pflip);
        logic [11:0] bits;
        logic        rdy0;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (PAR == 1) bits[9] = (^d) ^ pflip;
        bits[9+PAR] = stop;
        rise_at = -1;
        rdy0 = rd_rdy;
        for (int k = 0; k < (10 + PAR) * CPB; k++) begin
            @(negedge clk);
            if (!rdy0 && rd_rdy && rise_at < 0) rise_at = k;
            rx = bits[k / CPB];
        end
        if (stop && !pflip) begin
            if (sbq.size() < DEPTH) sbq.push_back(d);
            else exp_ovr = 1'b1;
        end
    endtask

    task automatic pop_expect(input string name);
        logic [7:0] exp;
        int         w;
        w = 0;
        @(negedge clk);
        while (!rd_rdy && w < 40) begin
            @(negedge clk);
            w++;
        end
        check({name, "_rdy"}, {31'd0, rd_rdy}, 32'd1);
        if (sbq.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL %s: got byte %0h expected none queued", name, dout);
        end else begin
            exp = sbq.pop_front();
            check({name, "_dout"}, {24'd0, dout}, {24'd0, exp});
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] part;
        vt[0] = '{8'h01, 1'b1, 1'b0};
        vt[1] = '{8'h80, 1'b1, 1'b0};
        vt[2] = '{8'h55, 1'b1, 1'b0};
        vt[3] = '{8'hAA, 1'b1, 1'b0};
        vt[4] = '{8'h00, 1'b1, 1'b0};
        vt[5] = '{8'h3C, 1'b0, 1'b1};
        vt[6] = '{8'hFF, 1'b1, 1'b0};
        vt[7] = '{8'hA5, 1'b1, 1'b0};
        exp_ovr = 1'b0;

        rst = 1'b1; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(1);
        check("rst_dout", {24'd0, dout}, 32'd0);
        check("rst_rdy", {31'd0, rd_rdy}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);

        // Single byte and its latency from the start edge.
        send(8'hE8, 1'b1, 1'b0);
        check("latency", {31'd0, (rise_at >= 150 + 16 * PAR) && (rise_at <= 156 + 16 * PAR)}, 32'd1);
        pop_expect("e8");
        check("e8_empty", {31'd0, rd_rdy}, 32'd0);

        // Pop request while empty must not move the pointers.
        rd_en = 1'b1;
        idle(2);
        rd_en = 1'b0;
        check("empty_pop", {31'd0, rd_rdy}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            send(vt[i].d, vt[i].stop, 1'b0);
            if (!vt[i].stop) begin
                idle(3);
                rx = 1'b1;
                idle(4);
            end
            idle(1);
            check($sformatf("vec%0d_ferr", i), {31'd0, frame_err}, {31'd0, vt[i].exp_ferr});
            check($sformatf("vec%0d_rdy", i), {31'd0, rd_rdy}, {31'd0, ~vt[i].exp_ferr});
            if (!vt[i].exp_ferr) pop_expect($sformatf("vec%0d", i));
            pulse_clr();
            check($sformatf("vec%0d_clr", i), {31'd0, frame_err}, 32'd0);
        end

        // Burst of four with a stalled consumer.
        send(8'h01, 1'b1, 1'b0);
        send(8'h80, 1'b1, 1'b0);
        send(8'h55, 1'b1, 1'b0);
        send(8'hAA, 1'b1, 1'b0);
        idle(1);
        check("burst_ovr", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < 4; i++) pop_expect($sformatf("burst%0d", i));
        check("burst_empty", {31'd0, rd_rdy}, 32'd0);

        // Fifth byte into a full FIFO is dropped.
        exp_ovr = 1'b0;
        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        send(8'h33, 1'b1, 1'b0);
        send(8'h44, 1'b1, 1'b0);
        send(8'h99, 1'b1, 1'b0);
        idle(1);
        check("ovr_set", {31'd0, overrun}, {31'd0, exp_ovr});
        for (int i = 0; i < 4; i++) pop_expect($sformatf("ovr%0d", i));
        check("ovr_empty", {31'd0, rd_rdy}, 32'd0);
        pulse_clr();
        check("ovr_clr", {31'd0, overrun}, 32'd0);

        // Short low glitch is rejected at the start-bit midpoint.
        rx = 1'b0;
        idle(4);
        check("glitch_busy", {31'd0, rx_busy}, 32'd1);
        rx = 1'b1;
        idle(20);
        check("glitch_idle", {31'd0, rx_busy}, 32'd0);
        check("glitch_rdy", {31'd0, rd_rdy}, 32'd0);
        check("glitch_ferr", {31'd0, frame_err}, 32'd0);

        // Bad stop followed by a break: one error, FSM parks until the line rises.
        send(8'h3C, 1'b0, 1'b0);
        idle(40);
        check("brk_ferr", {31'd0, frame_err}, 32'd1);
        check("brk_rdy", {31'd0, rd_rdy}, 32'd0);
        check("brk_busy", {31'd0, rx_busy}, 32'd1);
        rx = 1'b1;
        idle(5);
        check("brk_release", {31'd0, rx_busy}, 32'd0);
        pulse_clr();
        send(8'h3C, 1'b1, 1'b0);
        pop_expect("brk_3c");

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1);
        idle(2);
        check("par_ferr", {31'd0, frame_err}, 32'd1);
        check("par_rdy", {31'd0, rd_rdy}, 32'd0);
        check("par_busy", {31'd0, rx_busy}, 32'd0);
        pulse_clr();
        send(8'h07, 1'b1, 1'b0);
        pop_expect("par_07");
`endif

        // Reset in the middle of a frame with a byte stored and an error latched.
        send(8'h5A, 1'b1, 1'b0);
        send(8'h3C, 1'b0, 1'b0);
        rx = 1'b1;
        idle(3);
        part = 8'hE8;
        rx = 1'b0;
        idle(CPB);
        for (int b = 0; b < 4; b++) begin
            rx = part[b];
            idle(CPB);
        end
        check("pre_rst_busy", {31'd0, rx_busy}, 32'd1);
        check("pre_rst_rdy", {31'd0, rd_rdy}, 32'd1);
        rst = 1'b1;
        rx = 1'b1;
        idle(1);
        check("mid_rst_dout", {24'd0, dout}, 32'd0);
        check("mid_rst_rdy", {31'd0, rd_rdy}, 32'd0);
        check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
        check("mid_rst_ovr", {31'd0, overrun}, 32'd0);
        check("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
        rst = 1'b0;
        sbq.delete();
        idle(40);
        check("post_rst_busy", {31'd0, rx_busy}, 32'd0);
        send(8'hC3, 1'b1, 1'b0);
        pop_expect("post_rst_c3");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
